// File: rtl/skinny_sbox8_dom1_seq_ctrl_if.sv
// Handshake and data bundle of the masked Skinny-128 S-box layer sequencer.
// It carries the state input, the PRNG mask stream and the substituted state output.
interface skinny_sbox8_dom1_seq_ctrl_if #(
    parameter int NSB = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     s1_i;
    logic [127:0]     s0_i;
    logic [8*NSB-1:0] rnd_i;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     s1_o;
    logic [127:0]     s0_o;

    modport master (
        output in_valid, s1_i, s0_i, rnd_i, rnd_valid, out_ready,
        input  in_ready, rnd_ready, out_valid, s1_o, s0_o
    );

    modport slave (
        input  in_valid, s1_i, s0_i, rnd_i, rnd_valid, out_ready,
        output in_ready, rnd_ready, out_valid, s1_o, s0_o
    );
endinterface

// File: rtl/skinny_sbox8_dom1_seq_ctrl.sv
// First-order DOM S-box layer of masked Skinny-128.
// skinny_sbox8_dom1_sni_non_pipelined: one masked 8-bit S-box. Its four NOR layers are
// DOM AND gates with one fresh bit each. Partial products of the first three layers are
// registered, so with stable inputs the result settles after three edges and is sampled
// by the sequencer on the fourth.
// skinny_sbox8_dom1_seq_ctrl: pushes the 16 state bytes through NSB instances in batches.
module skinny_sbox8_dom1_sni_non_pipelined (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x0_i,
    input  logic [7:0] x1_i,
    input  logic [7:0] r_i,
    output logic [7:0] y0_o,
    output logic [7:0] y1_o
);
    // Bit permutation between NOR layers.
    function automatic logic [7:0] perm8(input logic [7:0] x);
        return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    endfunction

    // Final swap of bits 1 and 2.
    function automatic logic [7:0] swap8(input logic [7:0] x);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

    // DOM partial products for NOR(x3,x2) -> bit 0 and NOR(x7,x6) -> bit 4.
    // Share 0 carries the operand inversions, so ~a = (~a0) ^ a1.
    // Layout per gate: {a1b1, a1b0^r, a0b1^r, a0b0}.
    function automatic logic [7:0] dom_prod(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [1:0] r);
        logic la0, lb0, la1, lb1, ha0, hb0, ha1, hb1;
        la0 = ~a0[2];
        lb0 = ~a0[3];
        la1 = a1[2];
        lb1 = a1[3];
        ha0 = ~a0[6];
        hb0 = ~a0[7];
        ha1 = a1[6];
        hb1 = a1[7];
        return {ha1 & hb1, (ha1 & hb0) ^ r[1], (ha0 & hb1) ^ r[1], ha0 & hb0,
                la1 & lb1, (la1 & lb0) ^ r[0], (la0 & lb1) ^ r[0], la0 & lb0};
    endfunction

    // Share-0 compression of the partial products into bits 0 and 4.
    function automatic logic [7:0] mix_sh0(input logic [7:0] x, input logic [7:0] p);
        return x ^ {3'b000, p[4] ^ p[5], 3'b000, p[0] ^ p[1]};
    endfunction

    // Share-1 compression of the partial products into bits 0 and 4.
    function automatic logic [7:0] mix_sh1(input logic [7:0] x, input logic [7:0] p);
        return x ^ {3'b000, p[7] ^ p[6], 3'b000, p[3] ^ p[2]};
    endfunction

    logic [7:0] p0_s, p1_s, p2_s, p3_s;
    logic [7:0] p0_q, p1_q, p2_q;
    logic [7:0] a0_1_s, a1_1_s, a0_2_s, a1_2_s, a0_3_s, a1_3_s;

    assign p0_s   = dom_prod(x0_i, x1_i, r_i[1:0]);
    assign a0_1_s = perm8(mix_sh0(x0_i, p0_q));
    assign a1_1_s = perm8(mix_sh1(x1_i, p0_q));
    assign p1_s   = dom_prod(a0_1_s, a1_1_s, r_i[3:2]);
    assign a0_2_s = perm8(mix_sh0(a0_1_s, p1_q));
    assign a1_2_s = perm8(mix_sh1(a1_1_s, p1_q));
    assign p2_s   = dom_prod(a0_2_s, a1_2_s, r_i[5:4]);
    assign a0_3_s = perm8(mix_sh0(a0_2_s, p2_q));
    assign a1_3_s = perm8(mix_sh1(a1_2_s, p2_q));
    assign p3_s   = dom_prod(a0_3_s, a1_3_s, r_i[7:6]);
    assign y0_o   = swap8(mix_sh0(a0_3_s, p3_s));
    assign y1_o   = swap8(mix_sh1(a1_3_s, p3_s));

    // Partial-product registers separating the DOM layers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q <= 8'h00;
            p1_q <= 8'h00;
            p2_q <= 8'h00;
        end else begin
            p0_q <= p0_s;
            p1_q <= p1_s;
            p2_q <= p2_s;
        end
    end
endmodule

module skinny_sbox8_dom1_seq_ctrl #(
    parameter int NSB = 4,
    parameter int LAT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    skinny_sbox8_dom1_seq_ctrl_if.slave   bus
);
    localparam int NB = 16 / NSB;
    localparam int W  = 8 * NSB;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     batch_q, batch_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   w0_q, w0_d, w1_q, w1_d;
    logic [W-1:0]   op0_q, op0_d, op1_q, op1_d, r_q, r_d;
    logic [W-1:0]   sb0_s, sb1_s;
    logic [6:0]     base_s;
    logic           last_cnt_s, last_batch_s;
    logic           in_ready_s, out_valid_s, rnd_ready_s;

    assign base_s       = 7'(batch_q * W);
    assign last_cnt_s   = (cnt_q == CW'(LAT - 1));
    assign last_batch_s = (batch_q == 4'(NB - 1));

    // S-box instances fed only from the frozen operand and mask registers.
    for (genvar k = 0; k < NSB; k++) begin : g_sb
        skinny_sbox8_dom1_sni_non_pipelined u_sb (
            .clk   (clk),
            .rst_n (rst_n),
            .x0_i  (op0_q[8*k +: 8]),
            .x1_i  (op1_q[8*k +: 8]),
            .r_i   (r_q[8*k +: 8]),
            .y0_o  (sb0_s[8*k +: 8]),
            .y1_o  (sb1_s[8*k +: 8])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) state_d = S_FETCH;
                else              state_d = S_IDLE;
            end
            S_FETCH: begin
                if (bus.rnd_valid) state_d = S_HOLD;
                else               state_d = S_FETCH;
            end
            S_HOLD: begin
                if (last_cnt_s) begin
                    if (last_batch_s) state_d = S_DONE;
                    else              state_d = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
                else               state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        rnd_ready_s = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_s  = 1'b1;
            S_FETCH: rnd_ready_s = bus.rnd_valid;
            S_HOLD:  rnd_ready_s = 1'b0;
            S_DONE:  out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.rnd_ready = rnd_ready_s;
    assign bus.s0_o      = w0_q;
    assign bus.s1_o      = w1_q;

    // Datapath next-state: state capture, batch loading, in-place write-back.
    always_comb begin
        batch_d = batch_q;
        cnt_d   = cnt_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        r_d     = r_q;
        case (state_q)
            S_IDLE: begin
                op0_d = {W{1'b0}};
                op1_d = {W{1'b0}};
                r_d   = {W{1'b0}};
                if (bus.in_valid) begin
                    w0_d    = bus.s0_i;
                    w1_d    = bus.s1_i;
                    batch_d = 4'd0;
                end else begin
                    batch_d = batch_q;
                end
            end
            S_FETCH: begin
                if (bus.rnd_valid) begin
                    r_d   = bus.rnd_i;
                    op0_d = w0_q[base_s +: W];
                    op1_d = w1_q[base_s +: W];
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (last_cnt_s) begin
                    w0_d[base_s +: W] = sb0_s;
                    w1_d[base_s +: W] = sb1_s;
                    if (last_batch_s) batch_d = batch_q;
                    else              batch_d = batch_q + 4'd1;
                end else begin
                    batch_d = batch_q;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    op0_d = {W{1'b0}};
                    op1_d = {W{1'b0}};
                    r_d   = {W{1'b0}};
                end else begin
                    r_d = r_q;
                end
            end
            default: begin
                batch_d = 4'd0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_q <= 4'd0;
            cnt_q   <= {CW{1'b0}};
            w0_q    <= 128'd0;
            w1_q    <= 128'd0;
            op0_q   <= {W{1'b0}};
            op1_q   <= {W{1'b0}};
            r_q     <= {W{1'b0}};
        end else begin
            batch_q <= batch_d;
            cnt_q   <= cnt_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            r_q     <= r_d;
        end
    end
endmodule

// File: tb/tb_skinny_sbox8_dom1_seq_ctrl.sv
// Bench for the masked Skinny-128 S-box layer sequencer (NSB = 4, 1, 16).
module tb_skinny_sbox8_dom1_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [127:0] exp4[$];
    logic [127:0] exp1[$];
    logic [127:0] exp16[$];

    always #5 clk = ~clk;

    skinny_sbox8_dom1_seq_ctrl_if #(.NSB(4))  bus4  ();
    skinny_sbox8_dom1_seq_ctrl_if #(.NSB(1))  bus1  ();
    skinny_sbox8_dom1_seq_ctrl_if #(.NSB(16)) bus16 ();

    skinny_sbox8_dom1_seq_ctrl #(.NSB(4),  .LAT(4)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    skinny_sbox8_dom1_seq_ctrl #(.NSB(1),  .LAT(4)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    skinny_sbox8_dom1_seq_ctrl #(.NSB(16), .LAT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    // Skinny-128 8-bit S-box from its definition: four NOR-mix rounds, permutations between, final swap.
    function automatic logic [7:0] sbox_ref(input logic [7:0] xin);
        logic [7:0] x;
        x = xin;
        for (int i = 0; i < 4; i++) begin
            x = (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
            if (i < 3)
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
                    ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    function automatic logic [127:0] state_ref(input logic [127:0] u);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox_ref(u[8*i +: 8]);
        return y;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic new_rnd();
        bus4.rnd_i  = $urandom;
        bus1.rnd_i  = 8'($urandom);
        bus16.rnd_i = rand128();
    endtask

    // Single compare process: unmasked output of every DUT against its expectation queue.
    always @(negedge clk) begin
        if (bus4.out_valid) begin
            if (exp4.size() == 0) chk("sb4_unexpected_out", 128'd1, 128'd0);
            else begin
                chk("sb4_result", bus4.s0_o ^ bus4.s1_o, exp4[0]);
                if (bus4.out_ready) void'(exp4.pop_front());
            end
        end
        if (bus1.out_valid) begin
            if (exp1.size() == 0) chk("sb1_unexpected_out", 128'd1, 128'd0);
            else begin
                chk("sb1_result", bus1.s0_o ^ bus1.s1_o, exp1[0]);
                if (bus1.out_ready) void'(exp1.pop_front());
            end
        end
        if (bus16.out_valid) begin
            if (exp16.size() == 0) chk("sb16_unexpected_out", 128'd1, 128'd0);
            else begin
                chk("sb16_result", bus16.s0_o ^ bus16.s1_o, exp16[0]);
                if (bus16.out_ready) void'(exp16.pop_front());
            end
        end
    end

    // One state through the NSB=4 DUT. rnd_valid is low for cycles gs..gs+gl-1 after accept;
    // out_ready is held low for 'stall' DONE cycles while in_valid is pulsed.
    task automatic do4(input logic [127:0] s0, input logic [127:0] s1, input logic [127:0] expu,
                       input int gs, input int gl, input int stall, input int exp_lat);
        int cyc;
        int pulses;
        logic [127:0] h0, h1;
        exp4.push_back(expu);
        bus4.out_ready = (stall == 0);
        bus4.s0_i = s0;
        bus4.s1_i = s1;
        bus4.in_valid = 1'b1;
        #1;
        chk("in_ready_idle", 128'(bus4.in_ready), 128'd1);
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        new_rnd();
        pulses = 0;
        cyc = 0;
        while (cyc < 300) begin
            bus4.rnd_valid = !(cyc >= gs && cyc < gs + gl);
            @(negedge clk);
            if (bus4.out_valid) break;
            if (bus4.rnd_ready) pulses++;
            @(posedge clk); #1;
            new_rnd();
            cyc++;
        end
        chk("latency", 128'(cyc), 128'(exp_lat));
        chk("rnd_pulses", 128'(pulses), 128'd4);
        bus4.rnd_valid = 1'b1;
        #1;
        chk("rnd_ready_done", 128'(bus4.rnd_ready), 128'd0);
        h0 = bus4.s0_o;
        h1 = bus4.s1_o;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            bus4.in_valid = i[0];
            @(negedge clk);
            chk("stall_out_valid", 128'(bus4.out_valid), 128'd1);
            chk("stall_in_ready", 128'(bus4.in_ready), 128'd0);
            chk("stall_s0_stable", bus4.s0_o, h0);
            chk("stall_s1_stable", bus4.s1_o, h1);
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_ready_after_hs", 128'(bus4.in_ready), 128'd1);
        chk("out_valid_after_hs", 128'(bus4.out_valid), 128'd0);
    endtask

    // One state into both the NSB=1 and NSB=16 DUTs together.
    task automatic do_multi(input logic [127:0] s0, input logic [127:0] s1);
        int l1, l16;
        exp1.push_back(state_ref(s0 ^ s1));
        exp16.push_back(state_ref(s0 ^ s1));
        bus1.s0_i = s0;  bus1.s1_i = s1;  bus1.in_valid = 1'b1;
        bus16.s0_i = s0; bus16.s1_i = s1; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        bus16.in_valid = 1'b0;
        new_rnd();
        l1 = -1;
        l16 = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus1.out_valid && l1 < 0) l1 = c;
            if (bus16.out_valid && l16 < 0) l16 = c;
            if (l1 >= 0 && l16 >= 0) break;
            @(posedge clk); #1;
            new_rnd();
        end
        chk("latency_nsb1", 128'(l1), 128'd80);
        chk("latency_nsb16", 128'(l16), 128'd5);
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] m, st;
        rst_n = 1'b0;
        bus4.in_valid = 1'b0;  bus4.s0_i = 128'd0;  bus4.s1_i = 128'd0;
        bus4.rnd_valid = 1'b1; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0;  bus1.s0_i = 128'd0;  bus1.s1_i = 128'd0;
        bus1.rnd_valid = 1'b1; bus1.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.s0_i = 128'd0; bus16.s1_i = 128'd0;
        bus16.rnd_valid = 1'b1; bus16.out_ready = 1'b1;
        new_rnd();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(bus4.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus4.out_valid), 128'd0);
        chk("rst_rnd_ready", 128'(bus4.rnd_ready), 128'd0);
        chk("rst_s0_o", bus4.s0_o, 128'd0);
        chk("rst_s1_o", bus4.s1_o, 128'd0);
        chk("rst_in_ready_nsb1", 128'(bus1.in_ready), 128'd1);
        chk("rst_in_ready_nsb16", 128'(bus16.in_ready), 128'd1);
        rst_n = 1'b1;

        chk("ref_00", 128'(sbox_ref(8'h00)), 128'h65);
        chk("ref_01", 128'(sbox_ref(8'h01)), 128'h4C);
        chk("ref_ff", 128'(sbox_ref(8'hFF)), 128'hFF);

        // Zero state, equal shares.
        m = rand128();
        do4(m, m, {16{8'h65}}, 0, 0, 0, 20);
        // All-ones state, three different splits.
        for (int i = 0; i < 3; i++) begin
            m = rand128();
            do4(m, m ^ {128{1'b1}}, {16{8'hFF}}, 0, 0, 0, 20);
        end
        // rnd_valid low for three cycles in the second FETCH.
        st = rand128(); m = rand128();
        do4(m, m ^ st, state_ref(st), 5, 3, 0, 23);
        // Output back-pressure for ten cycles.
        st = rand128(); m = rand128();
        do4(m, m ^ st, state_ref(st), 0, 0, 10, 20);

        // Reset during the third HOLD cycle of the second batch.
        bus4.s0_i = rand128(); bus4.s1_i = rand128(); bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            new_rnd();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(bus4.out_valid), 128'd0);
        chk("midrst_in_ready", 128'(bus4.in_ready), 128'd1);
        chk("midrst_rnd_ready", 128'(bus4.rnd_ready), 128'd0);
        chk("midrst_s0_o", bus4.s0_o, 128'd0);
        chk("midrst_s1_o", bus4.s1_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        st = rand128(); m = rand128();
        do4(m, m ^ st, state_ref(st), 0, 0, 0, 20);

        // Random states on all three instance counts.
        for (int i = 0; i < 3; i++) begin
            st = rand128(); m = rand128();
            do4(m, m ^ st, state_ref(st), 0, 0, 0, 20);
        end
        for (int i = 0; i < 2; i++) begin
            st = rand128(); m = rand128();
            do_multi(m, m ^ st);
        end

        chk("sb4_queue_empty", 128'(exp4.size()), 128'd0);
        chk("sb1_queue_empty", 128'(exp1.size()), 128'd0);
        chk("sb16_queue_empty", 128'(exp16.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
